mcu_spi_link: RTL and testbench

- SPI target (mode 0) that sits between the MCU's SPI pins and the system control block.
- Deserialises MOSI bytes into the byte-strobe command stream the control block consumes: strobe, start-of-frame flag and data byte.
- Serialises the control block's response byte back onto MISO.
- All SPI signals are oversampled in the core clock domain; there is no second clock.

---
 rtl/mcu_spi_link.sv | 152 +++++++++++++++
 tb/tb_mcu_spi_link.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_link.sv
// mcu_spi_link: mode-0 SPI target, MOSI bytes to strobe stream, reply onto MISO.
// Define MCU_SPI_TIMEOUT_EN to abort a stalled byte after TIMEOUT_CYCLES idle clk.

module mcu_spi_link #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_data_strobe,
  output logic       mcu_data_start,
  output logic [7:0] mcu_data_out,
  input  logic [7:0] mcu_data_in
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [NS-1:0] ss_sync;
  logic [NS-1:0] sclk_sync;
  logic [NS-1:0] din_sync;
  logic          ss_d;
  logic          sclk_d;
  logic          ss_s;
  logic          sclk_s;
  logic          din_s;
  logic          ss_fall;
  logic          ss_rise;
  logic          sclk_rise;
  logic          sclk_fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx;
  logic [7:0]    tx;
  logic          first;
  logic          reload;
  logic          timeout;

  assign ss_s      = ss_sync[NS-1];
  assign sclk_s    = sclk_sync[NS-1];
  assign din_s     = din_sync[NS-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Synchronise SPI pins and keep one extra delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      din_sync  <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[NS-2:0], spi_io_ss};
      sclk_sync <= {sclk_sync[NS-2:0], spi_io_clk};
      din_sync  <= {din_sync[NS-2:0], spi_io_din};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout = (state == ACTIVE) && !sclk_rise && !sclk_fall &&
                   (idle_cnt == 16'(TIMEOUT_CYCLES));

  // Count clk cycles without an sclk edge while the frame is open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (state != ACTIVE || sclk_rise || sclk_fall || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame FSM: shift bits in/out, emit byte strobes, reload the reply
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      rx              <= '0;
      tx              <= '0;
      first           <= 1'b1;
      reload          <= 1'b0;
      mcu_data_strobe <= 1'b0;
      mcu_data_start  <= 1'b0;
      mcu_data_out    <= '0;
    end else begin
      mcu_data_strobe <= 1'b0;
      mcu_data_start  <= 1'b0;
      reload          <= mcu_data_strobe;
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          rx      <= '0;
          first   <= 1'b1;
          if (ss_fall) begin
            tx    <= mcu_data_in;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx      <= '0;
            first   <= 1'b1;
          end else if (timeout) begin
            bit_cnt <= '0;
            rx      <= '0;
            first   <= 1'b1;
            tx      <= mcu_data_in;
          end else begin
            if (sclk_rise) begin
              rx      <= {rx[6:0], din_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                mcu_data_out    <= {rx[6:0], din_s};
                mcu_data_strobe <= 1'b1;
                mcu_data_start  <= first;
                first           <= 1'b0;
              end
            end
            if (reload) begin
              tx <= mcu_data_in;
            end else if (sclk_fall) begin
              tx <= {tx[6:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_io_dout = (state == ACTIVE) && tx[7];

endmodule

// File: tb/tb_mcu_spi_link.sv
// tb_mcu_spi_link: directed + random SPI frames against a bit-stream model.
// Also exercises the idle abort when built with MCU_SPI_TIMEOUT_EN.

module tb_mcu_spi_link;

  localparam int SYNC = 2;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       din = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dout;
  logic       strobe;
  logic       start;
  logic [7:0] data_out;

  mcu_spi_link #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_io_ss      (ss),
    .spi_io_clk     (sclk),
    .spi_io_din     (din),
    .spi_io_dout    (dout),
    .mcu_data_strobe(strobe),
    .mcu_data_start (start),
    .mcu_data_out   (data_out),
    .mcu_data_in    (data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] d;
    int         c;
  } ev_t;

  int         total = 0;
  int         passed = 0;
  int         fails = 0;
  int         cyc = 0;
  int         start_bad = 0;
  ev_t        got_q[$];
  ev_t        exp_q[$];
  logic [7:0] reply_q[$];
  logic [7:0] given_q[$];
  logic [7:0] miso_q[$];
  int         nbit = 0;
  int         nbyte = 0;
  logic [7:0] acc = 8'h00;
  logic [7:0] miso_acc = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (strobe === 1'b1) got_q.push_back('{start, data_out, cyc});
    else if (start !== 1'b0) start_bad++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (strobe === 1'b1) begin
      if (reply_q.size() > 0) data_in = reply_q.pop_front();
      else data_in = 8'($urandom);
      given_q.push_back(data_in);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) din = b;
    @(negedge clk) sclk = 1'b1;
    miso_acc = {miso_acc[6:0], dout};
    acc = {acc[6:0], b};
    nbit++;
    if (nbit % 8 == 0) begin
      exp_q.push_back('{(nbyte == 0), acc, cyc + SYNC + 1});
      miso_q.push_back(miso_acc);
      nbyte++;
    end
    repeat (2) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7-i]);
  endtask

  task automatic frame_begin();
    @(negedge clk) ss = 1'b0;
    nbit = 0;
    nbyte = 0;
    miso_q.delete();
    given_q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk) ss = 1'b1;
    repeat (4) @(negedge clk);
    nbit = 0;
    nbyte = 0;
  endtask

  task automatic verify(input string tag, input bit with_miso);
    int n;
    chk($sformatf("%s count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data%0d", tag, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s start%0d", tag, i), got_q[i].st, exp_q[i].st);
      chk($sformatf("%s lat%0d", tag, i), got_q[i].c, exp_q[i].c);
    end
    if (exp_q.size() > 0)
      chk($sformatf("%s hold", tag), data_out, exp_q[exp_q.size()-1].d);
    if (with_miso) begin
      for (int k = 1; k < miso_q.size(); k++)
        chk($sformatf("%s miso%0d", tag, k), miso_q[k], given_q[k-1]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int nb;

    repeat (3) @(negedge clk);
    chk("rst strobe", strobe, 1'b0);
    chk("rst start", start, 1'b0);
    chk("rst data", data_out, 8'h00);
    chk("rst dout", dout, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    reply_q = '{8'h5C, 8'h42, 8'h02};
    frame_begin();
    for (int i = 0; i < 4; i++) send_bits(8'h00, 8);
    frame_end();
    verify("zeros", 1'b1);

    frame_begin();
    send_bits(8'h04, 8);
    send_bits(8'h53, 8);
    send_bits(8'h02, 8);
    frame_end();
    verify("cmd", 1'b1);

    frame_begin();
    send_bits(8'($urandom), 5);
    frame_end();
    frame_begin();
    send_bits(8'hA5, 8);
    frame_end();
    verify("partial", 1'b1);

    frame_begin();
    send_bits(8'h96, 8);
    send_bits(8'h69, 8);
    send_bits(8'($urandom), 3);
    verify("prerst", 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("mid strobe", strobe, 1'b0);
    chk("mid start", start, 1'b0);
    chk("mid data", data_out, 8'h00);
    chk("mid dout", dout, 1'b0);
    ss = 1'b1;
    sclk = 1'b0;
    nbit = 0;
    nbyte = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst none", got_q.size(), 0);
    frame_begin();
    send_bits(8'h3C, 8);
    frame_end();
    verify("postrst", 1'b1);

    for (int f = 0; f < 4; f++) begin
      nb = $urandom_range(1, 3);
      frame_begin();
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        send_bits(b, 8);
      end
      if (f[0]) send_bits(8'($urandom), $urandom_range(1, 7));
      frame_end();
      verify($sformatf("b2b%0d", f), 1'b1);
    end

    frame_begin();
    send_bits(8'($urandom), 8);
    send_bits(8'($urandom), 3);
    repeat (TMO + 10) @(negedge clk);
`ifdef MCU_SPI_TIMEOUT_EN
    nbit = 0;
    nbyte = 0;
`endif
    send_bits(8'h81, 8);
    frame_end();
    verify("stall", 1'b0);

    chk("start idle low", start_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
